// File: rtl/mips_dmem_responder.sv
// Data-memory responder: accepts one word-addressed load/store at a time, inserts
// WAIT_CYCLES wait states, then returns a one-cycle ready pulse. DMEM_ERR_EN enables err.
module mips_dmem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept_c, commit_c;

    logic               we_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic               bad_q;

    logic               cur_we;
    logic [ADDR_W-1:0]  cur_idx;
    logic [31:0]        cur_wdata;
    logic [3:0]         cur_be;
    logic               cur_bad;
    logic               addr_bad_c;

    logic [31:0]        mem [DEPTH];

`ifdef DMEM_ERR_EN
    assign addr_bad_c = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
`else
    // Byte offset and upper bits are don't-care: addresses wrap onto the array.
    logic unused_addr;
    assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};
    assign addr_bad_c  = 1'b0;
`endif

    // With zero wait states the commit edge is also the acceptance edge, so use live inputs.
    always_comb begin
        cur_we    = we_q;
        cur_idx   = idx_q;
        cur_wdata = wdata_q;
        cur_be    = be_q;
        cur_bad   = bad_q;
        if (state_q == IDLE) begin
            cur_we    = we;
            cur_idx   = addr[ADDR_W+1:2];
            cur_wdata = wdata;
            cur_be    = be;
            cur_bad   = addr_bad_c;
        end
    end

    // Next-state logic; commit_c marks the edge that enters RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        commit_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    accept_c = 1'b1;
                    cnt_d    = CNT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = RESP;
                        commit_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            bad_q   <= 1'b0;
        end else if (accept_c) begin
            we_q    <= we;
            idx_q   <= addr[ADDR_W+1:2];
            wdata_q <= wdata;
            be_q    <= be;
            bad_q   <= addr_bad_c;
        end
    end

    // Array has no reset; only enabled bytes of a clean write are updated.
    always_ff @(posedge clk) begin
        if (commit_c && cur_we && !cur_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= commit_c;
            rdata <= (commit_c && !cur_we && !cur_bad) ? mem[cur_idx] : '0;
        end
    end

`ifdef DMEM_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= commit_c && cur_bad;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
